// File: rtl/uart_tx_wrapper.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit(s).
// Define UART_TX_TWO_STOP_EN to send two stop bits per frame instead of one.
module uart_tx_wrapper #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  parity_en,
    input  logic                  parity_type,
    output logic                  tx_out,
    output logic                  busy
);

    // state   | meaning
    // IDLE    | line high, waiting for data_valid
    // START   | start bit (low)
    // DATA    | data bit bit_q, LSB first
    // PARITY  | parity bit
    // STOP    | stop bit(s) (high)
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam int BW    = $clog2(2 * CLKS_PER_BIT) + 1;
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [BW-1:0]    BIT_LAST  = BW'(CLKS_PER_BIT - 1);
`ifdef UART_TX_TWO_STOP_EN
    localparam logic [BW-1:0]    STOP_LAST = BW'(2 * CLKS_PER_BIT - 1);
`else
    localparam logic [BW-1:0]    STOP_LAST = BW'(CLKS_PER_BIT - 1);
`endif
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);

    state_t                state_q, state_d;
    logic [BW-1:0]         baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  pen_q, pen_d;
    logic                  ptype_q, ptype_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            pen_q   <= 1'b0;
            ptype_q <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            pen_q   <= pen_d;
            ptype_q <= ptype_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        data_d  = data_q;
        pen_d   = pen_q;
        ptype_d = ptype_q;

        case (state_q)
            S_IDLE: begin
                if (data_valid) begin
                    state_d = S_START;
                    baud_d  = BIT_LAST;
                    bit_d   = '0;
                    data_d  = data;
                    pen_d   = parity_en;
                    ptype_d = parity_type;
                end
            end
            S_START: begin
                if (baud_q == '0) begin
                    state_d = S_DATA;
                    baud_d  = BIT_LAST;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            S_DATA: begin
                if (baud_q == '0) begin
                    baud_d = BIT_LAST;
                    if (bit_q == DATA_LAST) begin
                        state_d = pen_q ? S_PARITY : S_STOP;
                        baud_d  = pen_q ? BIT_LAST : STOP_LAST;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            S_PARITY: begin
                if (baud_q == '0) begin
                    state_d = S_STOP;
                    baud_d  = STOP_LAST;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            S_STOP: begin
                if (baud_q == '0) begin
                    state_d = S_IDLE;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the line changes right on the edge.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = 1'b1;
        case (state_d)
            S_IDLE:   busy_d = 1'b0;
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = data_q[bit_d];
            S_PARITY: tx_d = (^data_q) ^ ptype_q;
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx_out = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_wrapper.sv
// Self-checking bench for uart_tx_wrapper: one-clock-per-bit and four-clocks-per-bit instances.
module tb_uart_tx_wrapper;

    logic       clk = 1'b0;
    logic       rst;
    logic       dv1, dv4;
    logic [7:0] data;
    logic       pe, pt;
    logic       tx1, b1, tx4, b4;

    int errors = 0;
    int checks = 0;

`ifdef UART_TX_TWO_STOP_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

    always #5 clk = ~clk;

    uart_tx_wrapper #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst), .data_valid(dv1), .data(data),
        .parity_en(pe), .parity_type(pt), .tx_out(tx1), .busy(b1)
    );

    uart_tx_wrapper #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst(rst), .data_valid(dv4), .data(data),
        .parity_en(pe), .parity_type(pt), .tx_out(tx4), .busy(b4)
    );

    typedef struct {
        logic [7:0] d;
        logic       p_en;
        logic       p_ty;
        logic       exp_par;
        int         exp_bits;   // line bits with a single stop bit
    } vec_t;

    logic exp_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic get_tx(input int cpb);
        return (cpb == 4) ? tx4 : tx1;
    endfunction

    function automatic logic get_busy(input int cpb);
        return (cpb == 4) ? b4 : b1;
    endfunction

    task automatic set_dv(input int cpb, input logic v);
        if (cpb == 4) dv4 = v;
        else          dv1 = v;
    endtask

    // Reference: list the line level for every clock of the frame.
    task automatic model_frame(input logic [7:0] d, input logic p_en, input logic p_ty,
                               input int cpb, output logic par);
        logic bits[$];
        par = logic'(($countones(d) + int'(p_ty)) % 2);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (p_en) bits.push_back(par);
        for (int i = 0; i < NSTOP; i++) bits.push_back(1'b1);
        exp_q.delete();
        foreach (bits[i])
            for (int k = 0; k < cpb; k++) exp_q.push_back(bits[i]);
    endtask

    // Sends one frame, checks every cycle, and ends on the idle cycle after it.
    task automatic run_frame(input int cpb, input logic [7:0] d, input logic p_en,
                             input logic p_ty, input logic hold, input logic isolate,
                             input string name, output int busy_cnt, output logic par_seen);
        logic par;
        int   par_pos;
        model_frame(d, p_en, p_ty, cpb, par);
        par_pos  = 9 * cpb;
        busy_cnt = 0;
        par_seen = 1'bx;
        data = d; pe = p_en; pt = p_ty;
        set_dv(cpb, 1'b1);
        step();
        if (!hold) set_dv(cpb, 1'b0);
        foreach (exp_q[i]) begin
            if (isolate && i == 2 * cpb) begin
                data = ~d;
                pt   = ~pt;
                pe   = ~pe;
            end
            if (i == par_pos) par_seen = get_tx(cpb);
            if (get_busy(cpb)) busy_cnt++;
            chk({name, "_tx"}, get_tx(cpb), exp_q[i]);
            chk({name, "_busy"}, get_busy(cpb), 1'b1);
            step();
        end
        chk({name, "_gap_tx"}, get_tx(cpb), 1'b1);
        chk({name, "_gap_busy"}, get_busy(cpb), 1'b0);
    endtask

    vec_t vecs[8];

    initial begin
        int   bc;
        logic ps;

        vecs[0] = '{8'hAA, 1'b1, 1'b1, 1'b1, 11};
        vecs[1] = '{8'h55, 1'b1, 1'b0, 1'b0, 11};
        vecs[2] = '{8'hAA, 1'b0, 1'b0, 1'b0, 10};
        vecs[3] = '{8'h01, 1'b1, 1'b0, 1'b1, 11};
        vecs[4] = '{8'h01, 1'b1, 1'b1, 1'b0, 11};
        vecs[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, 11};
        vecs[6] = '{8'h00, 1'b1, 1'b0, 1'b0, 11};
        vecs[7] = '{8'h07, 1'b1, 1'b1, 1'b0, 11};

        // Reset held with data_valid high: nothing may start.
        rst = 1'b1; dv1 = 1'b1; dv4 = 1'b1;
        data = 8'hAA; pe = 1'b1; pt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_tx1", tx1, 1'b1);
            chk("rst_busy1", b1, 1'b0);
            chk("rst_tx4", tx4, 1'b1);
            chk("rst_busy4", b4, 1'b0);
        end
        dv4 = 1'b0;
        rst = 1'b0;
        // First edge with rst low captures the held request.
        run_frame(1, 8'hAA, 1'b1, 1'b1, 1'b0, 1'b0, "post_rst", bc, ps);

        foreach (vecs[v]) begin
            for (int c = 0; c < 2; c++) begin
                int cpb = (c == 0) ? 1 : 4;
                run_frame(cpb, vecs[v].d, vecs[v].p_en, vecs[v].p_ty, 1'b0, 1'b0, "vec", bc, ps);
                chk_int("vec_busy_len", bc, (vecs[v].exp_bits + NSTOP - 1) * cpb);
                if (vecs[v].p_en) chk("vec_parity", ps, vecs[v].exp_par);
            end
        end

        // data_valid held: back-to-back frames one idle cycle apart.
        for (int n = 0; n < 3; n++)
            run_frame(1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, "b2b", bc, ps);
        dv1 = 1'b0;
        step();
        chk("b2b_end_busy", b1, 1'b0);

        // Inputs changed mid-frame must not disturb the captured copy.
        run_frame(1, 8'hAA, 1'b1, 1'b1, 1'b0, 1'b1, "iso1", bc, ps);
        chk("iso1_parity", ps, 1'b1);
        run_frame(4, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b1, "iso4", bc, ps);
        chk("iso4_parity", ps, 1'b0);

        // Reset during DATA aborts at once.
        for (int c = 0; c < 2; c++) begin
            int cpb = (c == 0) ? 1 : 4;
            data = 8'h00; pe = 1'b1; pt = 1'b0;
            set_dv(cpb, 1'b1);
            step();
            set_dv(cpb, 1'b0);
            for (int i = 0; i < 3 * cpb; i++) step();
            chk("mid_pre_busy", get_busy(cpb), 1'b1);
            chk("mid_pre_tx", get_tx(cpb), 1'b0);
            rst = 1'b1;
            step();
            rst = 1'b0;
            chk("mid_rst_tx", get_tx(cpb), 1'b1);
            chk("mid_rst_busy", get_busy(cpb), 1'b0);
            step();
            chk("mid_after_tx", get_tx(cpb), 1'b1);
            chk("mid_after_busy", get_busy(cpb), 1'b0);
        end

        // Randomized frames against the reference model.
        for (int n = 0; n < 30; n++) begin
            int         cpb  = ($urandom_range(0, 1) == 0) ? 1 : 4;
            logic [7:0] d    = 8'($urandom);
            logic       en   = 1'($urandom);
            logic       ty   = 1'($urandom);
            logic       iso  = 1'($urandom);
            int         gap  = $urandom_range(0, 3);
            run_frame(cpb, d, en, ty, 1'b0, iso, "rnd", bc, ps);
            chk_int("rnd_busy_len", bc, (10 + int'(en) + NSTOP - 1) * cpb);
            for (int g = 0; g < gap; g++) begin
                step();
                chk("rnd_idle_tx", get_tx(cpb), 1'b1);
                chk("rnd_idle_busy", get_busy(cpb), 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
